// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU load/store port and a DMA/debug port.
// Define DMEM_ARB_FIXED_PRIO_EN to give the CPU fixed priority and drop the round-robin pointer.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [31:0]       dma_rdata,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  typedef struct packed {
    logic       is_dma;
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
  } cmd_t;

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic              cpu_done_d, cpu_err_d, dma_done_d;
  logic [31:0]       cpu_rdata_d, dma_rdata_d, ram_wdata_d;
  logic [3:0]        ram_we_d;
  logic [ADDR_W-1:0] ram_addr_d;

  logic [1:0]  cpu_lane;
  logic        cpu_misaligned;
  logic [3:0]  cpu_mask;
  logic [31:0] cpu_lane_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] cpu_load;

  // Upper byte-address bits lie outside the RAM and are deliberately ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[31:ADDR_W+2];

  assign cpu_lane = cpu_addr[1:0];

  // Grant decision, only ever in IDLE
`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign cpu_gnt = (state_q == IDLE) && cpu_req;
`else
  logic ptr_dma_q;

  assign cpu_gnt = (state_q == IDLE) && cpu_req && (!dma_req || !ptr_dma_q);

  // Pointer moves to the side that did not win the grant
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_dma_q <= 1'b0;
    end else if (cpu_gnt) begin
      ptr_dma_q <= 1'b1;
    end else if (dma_gnt) begin
      ptr_dma_q <= 1'b0;
    end
  end
`endif
  assign dma_gnt = (state_q == IDLE) && dma_req && !cpu_gnt;

  // CPU store lane enables, replicated write data and alignment check
  always_comb begin
    cpu_mask       = 4'b1111;
    cpu_lane_wdata = cpu_wdata;
    cpu_misaligned = 1'b0;
    case (cpu_size)
      2'b00: begin
        cpu_mask       = 4'b0001 << cpu_lane;
        cpu_lane_wdata = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        cpu_mask       = cpu_lane[1] ? 4'b1100 : 4'b0011;
        cpu_lane_wdata = {2{cpu_wdata[15:0]}};
        cpu_misaligned = cpu_lane[0];
      end
      default: cpu_misaligned = (cpu_lane != 2'b00);
    endcase
  end

  // CPU load lane select and extension from the latched command
  always_comb begin
    rd_byte = ram_rdata[{cmd_q.lane, 3'b000} +: 8];
    rd_half = cmd_q.lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (cmd_q.size)
      2'b00:   cpu_load = cmd_q.uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   cpu_load = cmd_q.uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: cpu_load = ram_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    cpu_done_d  = 1'b0;
    cpu_err_d   = 1'b0;
    cpu_rdata_d = cpu_rdata;
    dma_done_d  = 1'b0;
    dma_rdata_d = dma_rdata;
    ram_we_d    = 4'b0000;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;

    case (state_q)
      IDLE: begin
        if (cpu_gnt) begin
          cmd_d = '{is_dma: 1'b0, we: cpu_we, size: cpu_size, uns: cpu_unsigned, lane: cpu_lane};
          if (cpu_misaligned) begin
            // Misaligned access completes at once with an error and never touches the RAM
            cpu_done_d  = 1'b1;
            cpu_err_d   = 1'b1;
            cpu_rdata_d = '0;
          end else begin
            state_d     = ISSUE;
            ram_addr_d  = cpu_addr[ADDR_W+1:2];
            ram_wdata_d = cpu_lane_wdata;
            ram_we_d    = cpu_we ? cpu_mask : 4'b0000;
          end
        end else if (dma_gnt) begin
          cmd_d       = '{is_dma: 1'b1, we: dma_we, size: 2'b10, uns: 1'b0, lane: 2'b00};
          state_d     = ISSUE;
          ram_addr_d  = dma_addr;
          ram_wdata_d = dma_wdata;
          ram_we_d    = {4{dma_we}};
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (cmd_q.we) begin
          state_d    = IDLE;
          cpu_done_d = !cmd_q.is_dma;
          dma_done_d = cmd_q.is_dma;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          state_d = IDLE;
          if (cmd_q.is_dma) begin
            dma_done_d  = 1'b1;
            dma_rdata_d = ram_rdata;
          end else begin
            cpu_done_d  = 1'b1;
            cpu_rdata_d = cpu_load;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      dma_done  <= 1'b0;
      dma_rdata <= '0;
      ram_we    <= 4'b0000;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      cpu_done  <= cpu_done_d;
      cpu_err   <= cpu_err_d;
      cpu_rdata <= cpu_rdata_d;
      dma_done  <= dma_done_d;
      dma_rdata <= dma_rdata_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: behavioural RAM, reference memory model, grant-order and latency checks.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0, cpu_unsigned = 1'b0;
  logic [1:0]        cpu_size = 2'b10;
  logic [31:0]       cpu_addr = '0, cpu_wdata = '0;
  logic              cpu_gnt, cpu_done, cpu_err;
  logic [31:0]       cpu_rdata;
  logic              dma_req = 1'b0, dma_we = 1'b0;
  logic [ADDR_W-1:0] dma_addr = '0;
  logic [31:0]       dma_wdata = '0;
  logic              dma_gnt, dma_done;
  logic [31:0]       dma_rdata;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = '0;

  typedef struct packed {
    logic        chk;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        cpu_q[$];
  exp_t        dma_q[$];
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int          n_tests = 0;
  int          n_fail  = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
    .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  // One-cycle-latency byte-writable RAM
  always @(posedge clock) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    return (sz == 2'b01) ? a[0] : ((sz[1] == 1'b1) && (a != 2'b00));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic u, input logic [1:0] a);
    logic [31:0] sh;
    sh = w >> (8 * a);
    case (sz)
      2'b00:   return u ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return u ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] r, tmp;
    int          off;
    logic        hit;
    r = w;
    for (int i = 0; i < 4; i++) begin
      off = i - int'(a);
      case (sz)
        2'b00:   hit = (off == 0);
        2'b01:   hit = (off == 0) || (off == 1);
        default: hit = 1'b1;
      endcase
      if (hit) begin
        tmp = wd >> (8 * off);
        r[8*i +: 8] = tmp[7:0];
      end
    end
    return r;
  endfunction

  // Completion monitor: every done pops one expectation
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (cpu_done) begin
        if (cpu_q.size() == 0) check_eq("cpu_done_unexpected", 32'(1), 32'(0));
        else begin
          e = cpu_q.pop_front();
          check_eq("cpu_err", 32'(cpu_err), 32'(e.err));
          if (e.chk) check_eq("cpu_rdata", cpu_rdata, e.data);
        end
      end
      if (dma_done) begin
        if (dma_q.size() == 0) check_eq("dma_done_unexpected", 32'(1), 32'(0));
        else begin
          e = dma_q.pop_front();
          if (e.chk) check_eq("dma_rdata", dma_rdata, e.data);
        end
      end
    end
  end

  task automatic cpu_op(input logic we, input logic [1:0] sz, input logic u,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int gw, output int lat, output logic [3:0] we1,
                        output logic [ADDR_W-1:0] addr1, output logic [31:0] wd1,
                        output logic [31:0] rd);
    exp_t e;
    logic got;
    int   wi;
    gw = 0; lat = 0; we1 = 'x; addr1 = 'x; wd1 = 'x; rd = 'x; got = 1'b0;
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_unsigned = u; cpu_addr = addr; cpu_wdata = wd;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (cpu_gnt) begin got = 1'b1; break; end
      gw++;
    end
    if (!got) begin
      check_eq("cpu_gnt_timeout", 32'(0), 32'(1));
      cpu_req = 1'b0;
      return;
    end
    wi     = int'(addr[ADDR_W+1:2]);
    e.err  = is_misaligned(sz, addr[1:0]);
    e.chk  = !we || e.err;
    e.data = e.err ? 32'h0 : model_load(ref_mem[wi], sz, u, addr[1:0]);
    if (we && !e.err) ref_mem[wi] = model_store(ref_mem[wi], sz, addr[1:0], wd);
    cpu_q.push_back(e);
    @(posedge clock); #1;
    cpu_req = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clock);
      if (k == 1) begin we1 = ram_we; addr1 = ram_addr; wd1 = ram_wdata; end
      if (cpu_done) begin lat = k; rd = cpu_rdata; break; end
    end
    if (lat == 0) check_eq("cpu_done_timeout", 32'(0), 32'(1));
  endtask

  task automatic dma_op(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                        output int lat, output logic [3:0] we1,
                        output logic [ADDR_W-1:0] addr1, output logic [31:0] rd);
    exp_t e;
    logic got;
    lat = 0; we1 = 'x; addr1 = 'x; rd = 'x; got = 1'b0;
    @(posedge clock); #1;
    dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (dma_gnt) begin got = 1'b1; break; end
    end
    if (!got) begin
      check_eq("dma_gnt_timeout", 32'(0), 32'(1));
      dma_req = 1'b0;
      return;
    end
    e.err  = 1'b0;
    e.chk  = !we;
    e.data = ref_mem[addr];
    if (we) ref_mem[addr] = wd;
    dma_q.push_back(e);
    @(posedge clock); #1;
    dma_req = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clock);
      if (k == 1) begin we1 = ram_we; addr1 = ram_addr; end
      if (dma_done) begin lat = k; rd = dma_rdata; break; end
    end
    if (lat == 0) check_eq("dma_done_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Both sides request continuously for four word writes each and the grant order is logged
  task automatic contention();
    logic order[$];
    int   nc, nd;
    exp_t e;
    nc = 0; nd = 0;
    e.chk = 1'b0; e.err = 1'b0; e.data = '0;
    @(posedge clock); #1;
    cpu_we = 1'b1; cpu_size = 2'b10; cpu_unsigned = 1'b0; cpu_addr = 32'h800; cpu_wdata = 32'hC0DE0001;
    dma_we = 1'b1; dma_addr = 14'h90; dma_wdata = 32'hD0DA0002;
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int cyc = 0; cyc < 200 && (nc < 4 || nd < 4); cyc++) begin
      @(negedge clock);
      check_eq("gnt_onehot", 32'(cpu_gnt & dma_gnt), 32'(0));
      if (cpu_gnt) begin
        order.push_back(1'b0); nc++;
        ref_mem[32'h200] = cpu_wdata;
        cpu_q.push_back(e);
      end
      if (dma_gnt) begin
        order.push_back(1'b1); nd++;
        ref_mem[dma_addr] = dma_wdata;
        dma_q.push_back(e);
      end
      @(posedge clock); #1;
      if (nc >= 4) cpu_req = 1'b0;
      if (nd >= 4) dma_req = 1'b0;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    check_eq("arb_grant_count", 32'(order.size()), 32'(8));
    for (int i = 0; i < order.size(); i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      check_eq($sformatf("arb_order_%0d", i), 32'(order[i]), 32'(i >= 4));
`else
      check_eq($sformatf("arb_order_%0d", i), 32'(order[i]), 32'(i % 2));
`endif
    end
    repeat (6) @(negedge clock);
  endtask

  initial begin
    int                gw, lat, cnt;
    logic [3:0]        we1;
    logic [ADDR_W-1:0] addr1;
    logic [31:0]       wd1, rd;
    logic              got;
    logic [1:0]        sz;
    logic [31:0]       a;
    logic              rw;

    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = 32'(i) * 32'h9E3779B1;
      ref_mem[i] = 32'(i) * 32'h9E3779B1;
    end

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_cpu_done",  32'(cpu_done), 32'(0));
    check_eq("rst_dma_done",  32'(dma_done), 32'(0));
    check_eq("rst_cpu_err",   32'(cpu_err),  32'(0));
    check_eq("rst_cpu_rdata", cpu_rdata, 32'h0);
    check_eq("rst_dma_rdata", dma_rdata, 32'h0);
    check_eq("rst_ram_we",    32'(ram_we),   32'(0));
    check_eq("rst_ram_addr",  32'(ram_addr), 32'(0));
    check_eq("rst_ram_wdata", ram_wdata, 32'h0);
    check_eq("rst_gnt",       32'({cpu_gnt, dma_gnt}), 32'(0));
    #1 reset = 1'b0;

    // Word store then load
    cpu_op(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, gw, lat, we1, addr1, wd1, rd);
    check_eq("sw_ram_we",   32'(we1),   32'hF);
    check_eq("sw_ram_addr", 32'(addr1), 32'h10);
    check_eq("sw_ram_wdata", wd1, 32'hDEADBEEF);
    check_eq("sw_latency",  32'(lat),   32'(2));
    cpu_op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, gw, lat, we1, addr1, wd1, rd);
    check_eq("lw_latency", 32'(lat), 32'(3));
    check_eq("lw_ram_we",  32'(we1), 32'(0));
    check_eq("lw_rdata",   rd, 32'hDEADBEEF);

    // Byte store and signed/unsigned byte loads
    cpu_op(1'b1, 2'b00, 1'b0, 32'h43, 32'h80, gw, lat, we1, addr1, wd1, rd);
    check_eq("sb_ram_we",    32'(we1), 32'h8);
    check_eq("sb_ram_wdata", wd1, 32'h80808080);
    cpu_op(1'b0, 2'b00, 1'b0, 32'h43, 32'h0, gw, lat, we1, addr1, wd1, rd);
    check_eq("lb_rdata", rd, 32'hFFFFFF80);
    cpu_op(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, gw, lat, we1, addr1, wd1, rd);
    check_eq("lbu_rdata", rd, 32'h00000080);

    // Misaligned half store
    cpu_op(1'b1, 2'b01, 1'b0, 32'h41, 32'hBEEF, gw, lat, we1, addr1, wd1, rd);
    check_eq("sh_mis_latency", 32'(lat), 32'(1));
    check_eq("sh_mis_ram_we",  32'(we1), 32'(0));
    @(negedge clock);
    check_eq("sh_mis_ram_we_after", 32'(ram_we), 32'(0));

    // DMA write, DMA read, CPU half loads of the same word
    dma_op(1'b1, 14'd5, 32'h12345678, lat, we1, addr1, rd);
    check_eq("dma_wr_latency", 32'(lat),   32'(2));
    check_eq("dma_wr_ram_we",  32'(we1),   32'hF);
    check_eq("dma_wr_ram_addr", 32'(addr1), 32'd5);
    dma_op(1'b0, 14'd5, 32'h0, lat, we1, addr1, rd);
    check_eq("dma_rd_latency", 32'(lat), 32'(3));
    check_eq("dma_rd_rdata",   rd, 32'h12345678);
    cpu_op(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, gw, lat, we1, addr1, wd1, rd);
    check_eq("lhu_rdata", rd, 32'h00001234);
    cpu_op(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, gw, lat, we1, addr1, wd1, rd);
    check_eq("lh_rdata", rd, 32'h00005678);

    // Random CPU traffic against the reference model
    for (int i = 0; i < 16; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'h100 + 32'($urandom_range(0, 31));
      rw = 1'($urandom_range(0, 1));
      cpu_op(rw, sz, 1'($urandom_range(0, 1)), a, $urandom, gw, lat, we1, addr1, wd1, rd);
      check_eq($sformatf("rand_latency_%0d", i), 32'(lat),
               is_misaligned(sz, a[1:0]) ? 32'(1) : (rw ? 32'(2) : 32'(3)));
    end

    // Contention from a fresh pointer
    do_reset();
    contention();

    // Reset while a DMA read is waiting on the RAM
    @(posedge clock); #1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 14'd5;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (dma_gnt) begin got = 1'b1; break; end
    end
    check_eq("abort_dma_gnt", 32'(got), 32'(1));
    @(posedge clock); #1 dma_req = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    check_eq("abort_ram_we", 32'(ram_we), 32'(0));
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (dma_done) cnt++;
    end
    check_eq("abort_no_dma_done", 32'(cnt), 32'(0));
    cpu_op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, gw, lat, we1, addr1, wd1, rd);
    check_eq("post_abort_gnt_wait", 32'(gw),  32'(0));
    check_eq("post_abort_latency",  32'(lat), 32'(3));
    check_eq("post_abort_rdata",    rd, 32'h80ADBEEF);

    repeat (4) @(negedge clock);
    check_eq("cpu_q_left", 32'(cpu_q.size()), 32'(0));
    check_eq("dma_q_left", 32'(dma_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM (14-bit word address, 4-bit byte write enable, 32-bit data) between two requesters:
  - the CPU load/store port;
  - a word-wide DMA/debug port.
- Sequences each access through a small FSM. Arbitrates round-robin.
- CPU side: generates byte-lane enables for byte/half/word stores, and extracts and extends loads.
- Sits between the memory stage / IO bridge and the RAM wrapper, which it drives directly.

Parameters:
- ADDR_W, 14, RAM word-address width.
- RD_LAT, 1, RAM read latency in cycles from address-valid edge to ram_rdata valid; legal range 1..3.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held with command stable until cpu_gnt.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- cpu_unsigned  in  1  load zero-extend (1) / sign-extend (0).
- cpu_addr  in  32  byte address; bits [ADDR_W+1:2] select the word.
- cpu_wdata  in  32  store data, right-aligned.
- cpu_gnt  out  1  combinational one-cycle accept pulse.
- cpu_done  out  1  registered one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_done; misaligned access.
- cpu_rdata  out  32  extended load data, valid with cpu_done.
- dma_req  in  1  DMA request; held until dma_gnt.
- dma_we  in  1  1 = full-word write.
- dma_addr  in  ADDR_W  word address.
- dma_wdata  in  32  write data.
- dma_gnt  out  1  combinational accept pulse.
- dma_done  out  1  registered completion pulse.
- dma_rdata  out  32  read word, valid with dma_done.
- ram_we  out  4  byte write enables to RAM.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  lane-positioned write data.
- ram_rdata  in  32  RAM read data.

Behaviour:
- Reset values (on reset, next edge):
  - state=IDLE, priority pointer=CPU;
  - all gnt/done/err=0, rdata=0;
  - ram_we=0, ram_addr=0, ram_wdata=0.
  - Reset mid-access abandons it with no done pulse. ram_we is low from the cycle after reset is sampled.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Exactly one gnt is asserted combinationally if any req is high.
  - If both requesters are high, the pointer side wins. The pointer then flips to the loser, so grants alternate under contention.
  - A single requester wins regardless of pointer; the pointer still flips to the other side.
  - On the grant edge the command is latched; go to ISSUE.
- ISSUE (1 cycle):
  - ram_addr and ram_wdata are driven from the latched command.
  - Write: ram_we = lane mask; next state IDLE; done pulses in the following cycle.
  - Read: ram_we=0; go to WAIT.
- WAIT: count RD_LAT cycles, then capture ram_rdata, pulse done with rdata, go to IDLE.
- ram_addr holds its last value outside ISSUE and WAIT. ram_we is nonzero only in ISSUE.
- CPU lane rules, with a = cpu_addr[1:0]:
  - Byte: we = 1<<a; wdata = byte replicated ×4.
  - Half: we = 0011 (a=00) or 1100 (a=10); wdata = half replicated ×2.
  - Word: we = 1111.
- Misaligned access (half with a[0]=1, or word with a≠0):
  - Still granted; no RAM write.
  - Done pulses with err=1 one cycle after grant, skipping ISSUE/WAIT; rdata=0.
- Load extraction: select the lane by a, then zero- or sign-extend to 32 bits.
- DMA accesses are always whole words (we=1111); DMA has no error output.
- Throughput:
  - Write: grant→done = 2 cycles.
  - Read: grant→done = RD_LAT+2 cycles.
  - Next grant no earlier than the cycle after done. IDLE on the done cycle may grant immediately.
- Request dropped before gnt: no access, and the pointer is unchanged.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRIO_EN.
- When defined: CPU always wins when both request (DMA can starve); the pointer register is removed.
- When undefined: round-robin as above.

Test Plan:
- Reset, then CPU sw 0xDEADBEEF at 0x40 → ram_we=1111, ram_addr=0x10 in ISSUE. A later CPU lw 0x40 → cpu_done 3 cycles after grant (RD_LAT=1), cpu_rdata=0xDEADBEEF.
- CPU sb 0x80 to addr 0x43 → ram_we=1000, ram_wdata=0x80808080. lb 0x43 → 0xFFFFFF80; lbu 0x43 → 0x00000080.
- CPU sh at 0x41 → cpu_done with cpu_err=1 one cycle after grant; ram_we stays 0000 throughout.
- cpu_req and dma_req held high continuously for 4 accesses each → grant order CPU, DMA, CPU, DMA…; no requester waits more than one foreign access. With DMEM_ARB_FIXED_PRIO_EN defined → all CPU grants first.
- DMA write 0x12345678 to word 5, then CPU lhu 0x16 → 0x00001234.
- Assert reset during WAIT of a DMA read → no dma_done. State is IDLE after the reset edge and the next request is granted normally.
